lc4_arith_rs: RTL and testbench
===============================

# lc4_arith_rs

Reservation station that feeds the LC4 arithmetic execute stage in the out-of-order core. It buffers dispatched ALU/branch-link instructions whose source operands may still be in flight, captures results broadcast on the common data bus (CDB), and issues the oldest operand-ready instruction as the `insn`/`pc`/`r1data`/`r2data` bundle the arithmetic stage consumes. Its results return on the CDB from the writeback side.

## Interface
- `ENTRIES`, 4: queue depth (2..8).
- `TAG_W`, 4: width of physical result tags.

- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous squash of all entries (mispredict recovery).
- `disp_valid` in 1: dispatch request.
- `disp_ready` out 1: a free entry exists this cycle.
- `disp_insn`, `disp_pc` in 16 each: instruction and its PC.
- `disp_tag` in TAG_W: destination tag, carried to issue.
- `disp_r1_rdy`, `disp_r2_rdy` in 1 each: operand value already valid.
- `disp_r1_tag`, `disp_r2_tag` in TAG_W each: producer tag when not ready.
- `disp_r1_data`, `disp_r2_data` in 16 each: operand value when ready.
- `cdb_valid` in 1, `cdb_tag` in TAG_W, `cdb_data` in 16: result broadcast.
- `issue_valid` out 1: an entry with both operands ready is offered.
- `issue_ready` in 1: execute stage accepts this cycle.
- `issue_insn`, `issue_pc`, `issue_r1data`, `issue_r2data` out 16 each; `issue_tag` out TAG_W.
- `count` out clog2(ENTRIES)+1: occupied entries.

## Operation
- Storage: collapsing queue, index 0 = oldest; entries 0..count-1 valid. Per entry: insn, pc, tag, and per operand {rdy, tag, data}.
- `disp_ready` = (count < ENTRIES). Not dependent on `issue_ready` (no pass-through when full).
- Dispatch fires on `disp_valid && disp_ready`; new entry written at index count, minus 1 if an issue fires the same cycle.
- Wakeup: for every resident entry operand with rdy=0 and `cdb_valid && cdb_tag == operand tag`: set rdy=1, data=`cdb_data`. Both operands of one entry may wake together.
- Dispatch bypass: a dispatching operand with rdy=0 whose tag matches a valid CDB broadcast that same cycle is stored rdy=1 with `cdb_data`.
- Select: lowest index with both rdy=1 as of current state; `issue_*` show that entry. CDB wakeups in cycle N don't count until N+1.
- Issue fires on `issue_valid && issue_ready`; selected entry removed and all higher entries shift down one, keeping age order.
- Selection is not held under backpressure: while `issue_ready`=0 an older entry that becomes ready replaces the offered one.
- When `issue_valid`=0 all `issue_*` data outputs drive 0.
- Priority: `rst` > `flush` > issue/dispatch/wakeup. On `rst` or `flush` every entry is invalidated next edge; a dispatch or issue presented that cycle is discarded (no entry kept, even if handshake signals look complete).
- `count` next = count + dispatch_fire − issue_fire.

## Timing
- After reset: `count`=0, `disp_ready`=1, `issue_valid`=0, all `issue_*` buses 0.
- Dispatch-to-issue latency: 1 cycle minimum (accepted at edge N with both operands ready -> `issue_valid` in cycle N+1).
- CDB-to-issue: broadcast in cycle N -> entry issuable in cycle N+1.
- Full: `disp_ready`=0 in the same cycle count reaches ENTRIES; returns to 1 the cycle after an issue fires.
- Full + issue + dispatch_valid same cycle: dispatch stalled; only issue fires.
- Empty: `issue_valid`=0 combinationally; no underflow of `count`.
- Issue, dispatch, and wakeup in one cycle are all applied; shifted entries keep wakeups received that cycle.

## Test plan
- Reset then dispatch ADD (insn 16'h1042, pc 16'h0010, both ready, r1=5, r2=7, tag 3) -> next cycle `issue_valid`=1, `issue_r1data`=5, `issue_r2data`=7, `issue_tag`=3; accept -> `count`=0.
- Dispatch A (r1 waiting tag 9), then B (ready) -> B issues first; CDB tag 9 data 16'hBEEF -> A issues next cycle with `issue_r1data`=16'hBEEF.
- Dispatch with r2 tag 5 not ready while CDB broadcasts tag 5 data 16'h0042 the same cycle -> entry issues next cycle with `issue_r2data`=16'h0042.
- Fill 4 entries with `issue_ready`=0 -> `disp_ready`=0, `count`=4; fifth dispatch held; raise `issue_ready` one cycle -> `count`=3, `disp_ready`=1, remaining order preserved (oldest ready issues first).
- Fill 3 entries, assert `flush` with simultaneous dispatch and `issue_ready`=1 -> next cycle `count`=0, `issue_valid`=0, all `issue_*`=0.
- Random dispatch/CDB/backpressure for 10k cycles against a scoreboard model -> every dispatched tag issues exactly once, with correct operand data and oldest-ready-first order.

Source files
------------

// File: rtl/lc4_arith_rs_if.sv
// lc4_arith_rs_if: dispatch, CDB and issue buses of the arithmetic reservation station
interface lc4_arith_rs_if #(
    parameter int ENTRIES = 4,
    parameter int TAG_W   = 4
);
    localparam int CW = $clog2(ENTRIES) + 1;
    logic             flush;
    logic             disp_valid;
    logic             disp_ready;
    logic [15:0]      disp_insn;
    logic [15:0]      disp_pc;
    logic [TAG_W-1:0] disp_tag;
    logic             disp_r1_rdy;
    logic             disp_r2_rdy;
    logic [TAG_W-1:0] disp_r1_tag;
    logic [TAG_W-1:0] disp_r2_tag;
    logic [15:0]      disp_r1_data;
    logic [15:0]      disp_r2_data;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [15:0]      cdb_data;
    logic             issue_valid;
    logic             issue_ready;
    logic [15:0]      issue_insn;
    logic [15:0]      issue_pc;
    logic [15:0]      issue_r1data;
    logic [15:0]      issue_r2data;
    logic [TAG_W-1:0] issue_tag;
    logic [CW-1:0]    count;

    modport master (
        output flush, disp_valid, disp_insn, disp_pc, disp_tag, disp_r1_rdy, disp_r2_rdy,
               disp_r1_tag, disp_r2_tag, disp_r1_data, disp_r2_data,
               cdb_valid, cdb_tag, cdb_data, issue_ready,
        input  disp_ready, issue_valid, issue_insn, issue_pc, issue_r1data, issue_r2data,
               issue_tag, count
    );

    modport slave (
        input  flush, disp_valid, disp_insn, disp_pc, disp_tag, disp_r1_rdy, disp_r2_rdy,
               disp_r1_tag, disp_r2_tag, disp_r1_data, disp_r2_data,
               cdb_valid, cdb_tag, cdb_data, issue_ready,
        output disp_ready, issue_valid, issue_insn, issue_pc, issue_r1data, issue_r2data,
               issue_tag, count
    );
endinterface

// File: rtl/lc4_arith_rs.sv
// lc4_arith_rs: collapsing-queue reservation station feeding the LC4 arithmetic stage
module lc4_arith_rs #(
    parameter int ENTRIES = 4,
    parameter int TAG_W   = 4
) (
    input logic          clk,
    input logic          rst,
    lc4_arith_rs_if.slave bus
);
    localparam int CW = $clog2(ENTRIES) + 1;
    localparam int IW = $clog2(ENTRIES);

    typedef struct packed {
        logic [15:0]      insn;
        logic [15:0]      pc;
        logic [TAG_W-1:0] tag;
        logic             r1_rdy;
        logic [TAG_W-1:0] r1_tag;
        logic [15:0]      r1_data;
        logic             r2_rdy;
        logic [TAG_W-1:0] r2_tag;
        logic [15:0]      r2_data;
    } ent_t;

    ent_t          ent_q [ENTRIES];
    ent_t          ent_d [ENTRIES];
    ent_t          woken [ENTRIES+1];
    ent_t          new_ent;
    logic [CW-1:0] cnt_q, cnt_d, widx;
    logic [IW-1:0] sel;
    logic          found, issue_fire, disp_fire;

    // pick the oldest resident entry whose operands are both ready
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = ENTRIES - 1; i >= 0; i--)
            if (CW'(i) < cnt_q && ent_q[i].r1_rdy && ent_q[i].r2_rdy) begin
                sel   = IW'(i);
                found = 1'b1;
            end
    end

    // wake operands from the CDB, collapse over the issued slot, append the dispatch
    always_comb begin
        issue_fire      = found && bus.issue_ready;
        disp_fire       = bus.disp_valid && bus.disp_ready;
        new_ent.insn    = bus.disp_insn;
        new_ent.pc      = bus.disp_pc;
        new_ent.tag     = bus.disp_tag;
        new_ent.r1_tag  = bus.disp_r1_tag;
        new_ent.r2_tag  = bus.disp_r2_tag;
        new_ent.r1_rdy  = bus.disp_r1_rdy || (bus.cdb_valid && bus.cdb_tag == bus.disp_r1_tag);
        new_ent.r2_rdy  = bus.disp_r2_rdy || (bus.cdb_valid && bus.cdb_tag == bus.disp_r2_tag);
        new_ent.r1_data = bus.disp_r1_rdy ? bus.disp_r1_data : bus.cdb_data;
        new_ent.r2_data = bus.disp_r2_rdy ? bus.disp_r2_data : bus.cdb_data;
        woken[ENTRIES]  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            woken[i] = ent_q[i];
            if (bus.cdb_valid && !ent_q[i].r1_rdy && ent_q[i].r1_tag == bus.cdb_tag) begin
                woken[i].r1_rdy  = 1'b1;
                woken[i].r1_data = bus.cdb_data;
            end
            if (bus.cdb_valid && !ent_q[i].r2_rdy && ent_q[i].r2_tag == bus.cdb_tag) begin
                woken[i].r2_rdy  = 1'b1;
                woken[i].r2_data = bus.cdb_data;
            end
        end
        widx = cnt_q - CW'(issue_fire);
        for (int i = 0; i < ENTRIES; i++) begin
            ent_d[i] = (issue_fire && IW'(i) >= sel) ? woken[i+1] : woken[i];
            if (disp_fire && CW'(i) == widx)
                ent_d[i] = new_ent;
        end
        cnt_d = bus.flush ? '0 : cnt_q + CW'(disp_fire) - CW'(issue_fire);
    end

    // occupancy is the only state needing reset; entries past count are don't-care
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign bus.disp_ready   = cnt_q < CW'(ENTRIES);
    assign bus.issue_valid  = found;
    assign bus.issue_insn   = found ? ent_q[sel].insn : '0;
    assign bus.issue_pc     = found ? ent_q[sel].pc : '0;
    assign bus.issue_r1data = found ? ent_q[sel].r1_data : '0;
    assign bus.issue_r2data = found ? ent_q[sel].r2_data : '0;
    assign bus.issue_tag    = found ? ent_q[sel].tag : '0;
    assign bus.count        = cnt_q;
endmodule

// File: tb/tb_lc4_arith_rs.sv
// tb_lc4_arith_rs: directed and random checks of the reservation station against a queue model
module tb_lc4_arith_rs;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lc4_arith_rs_if #(.ENTRIES(4), .TAG_W(4)) bus();
    lc4_arith_rs #(.ENTRIES(4), .TAG_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [15:0] insn;
        logic [15:0] pc;
        logic [3:0]  tag;
        bit          r1_rdy;
        logic [3:0]  r1_tag;
        logic [15:0] r1_data;
        bit          r2_rdy;
        logic [3:0]  r2_tag;
        logic [15:0] r2_data;
    } m_t;

    m_t mq[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int msel();
        foreach (mq[i])
            if (mq[i].r1_rdy && mq[i].r2_rdy)
                return i;
        return -1;
    endfunction

    task automatic model_update();
        int s;
        bit dfire;
        m_t n;
        if (rst || bus.flush) begin
            mq.delete();
            return;
        end
        s = msel();
        dfire = bus.disp_valid && mq.size() < 4;
        n.insn = bus.disp_insn;
        n.pc = bus.disp_pc;
        n.tag = bus.disp_tag;
        n.r1_rdy = bus.disp_r1_rdy;
        n.r1_tag = bus.disp_r1_tag;
        n.r1_data = bus.disp_r1_data;
        n.r2_rdy = bus.disp_r2_rdy;
        n.r2_tag = bus.disp_r2_tag;
        n.r2_data = bus.disp_r2_data;
        if (bus.cdb_valid && !n.r1_rdy && n.r1_tag == bus.cdb_tag) begin
            n.r1_rdy = 1;
            n.r1_data = bus.cdb_data;
        end
        if (bus.cdb_valid && !n.r2_rdy && n.r2_tag == bus.cdb_tag) begin
            n.r2_rdy = 1;
            n.r2_data = bus.cdb_data;
        end
        foreach (mq[i]) begin
            if (bus.cdb_valid && !mq[i].r1_rdy && mq[i].r1_tag == bus.cdb_tag) begin
                mq[i].r1_rdy = 1;
                mq[i].r1_data = bus.cdb_data;
            end
            if (bus.cdb_valid && !mq[i].r2_rdy && mq[i].r2_tag == bus.cdb_tag) begin
                mq[i].r2_rdy = 1;
                mq[i].r2_data = bus.cdb_data;
            end
        end
        if (s >= 0 && bus.issue_ready)
            mq.delete(s);
        if (dfire)
            mq.push_back(n);
    endtask

    task automatic compare();
        int s;
        s = msel();
        chk("count", int'(bus.count), mq.size());
        chk("disp_ready", int'(bus.disp_ready), int'(mq.size() < 4));
        chk("issue_valid", int'(bus.issue_valid), int'(s >= 0));
        if (s >= 0) begin
            chk("issue_insn", int'(bus.issue_insn), int'(mq[s].insn));
            chk("issue_pc", int'(bus.issue_pc), int'(mq[s].pc));
            chk("issue_r1data", int'(bus.issue_r1data), int'(mq[s].r1_data));
            chk("issue_r2data", int'(bus.issue_r2data), int'(mq[s].r2_data));
            chk("issue_tag", int'(bus.issue_tag), int'(mq[s].tag));
        end else begin
            chk("idle_insn", int'(bus.issue_insn), 0);
            chk("idle_pc", int'(bus.issue_pc), 0);
            chk("idle_r1data", int'(bus.issue_r1data), 0);
            chk("idle_r2data", int'(bus.issue_r2data), 0);
            chk("idle_tag", int'(bus.issue_tag), 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic idle();
        bus.flush = 0;
        bus.disp_valid = 0;
        bus.disp_insn = 0;
        bus.disp_pc = 0;
        bus.disp_tag = 0;
        bus.disp_r1_rdy = 0;
        bus.disp_r2_rdy = 0;
        bus.disp_r1_tag = 0;
        bus.disp_r2_tag = 0;
        bus.disp_r1_data = 0;
        bus.disp_r2_data = 0;
        bus.cdb_valid = 0;
        bus.cdb_tag = 0;
        bus.cdb_data = 0;
        bus.issue_ready = 0;
    endtask

    task automatic disp(input logic [15:0] insn, input logic [15:0] pc, input logic [3:0] tag,
                        input logic r1r, input logic [3:0] r1t, input logic [15:0] r1d,
                        input logic r2r, input logic [3:0] r2t, input logic [15:0] r2d);
        bus.disp_valid = 1;
        bus.disp_insn = insn;
        bus.disp_pc = pc;
        bus.disp_tag = tag;
        bus.disp_r1_rdy = r1r;
        bus.disp_r1_tag = r1t;
        bus.disp_r1_data = r1d;
        bus.disp_r2_rdy = r2r;
        bus.disp_r2_tag = r2t;
        bus.disp_r2_data = r2d;
    endtask

    initial begin
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
        tick();
        chk("rst_count", int'(bus.count), 0);
        chk("rst_disp_ready", int'(bus.disp_ready), 1);
        chk("rst_issue_valid", int'(bus.issue_valid), 0);
        chk("rst_issue_r1data", int'(bus.issue_r1data), 0);

        disp(16'h1042, 16'h0010, 4'd3, 1, 0, 16'd5, 1, 0, 16'd7);
        tick();
        bus.disp_valid = 0;
        chk("add_valid", int'(bus.issue_valid), 1);
        chk("add_insn", int'(bus.issue_insn), 'h1042);
        chk("add_r1", int'(bus.issue_r1data), 5);
        chk("add_r2", int'(bus.issue_r2data), 7);
        chk("add_tag", int'(bus.issue_tag), 3);
        bus.issue_ready = 1;
        tick();
        bus.issue_ready = 0;
        chk("add_drain", int'(bus.count), 0);

        disp(16'h2001, 16'h0020, 4'd1, 0, 4'd9, 16'd0, 1, 0, 16'd1);
        tick();
        disp(16'h2002, 16'h0022, 4'd2, 1, 0, 16'd2, 1, 0, 16'd3);
        tick();
        bus.disp_valid = 0;
        chk("young_first_tag", int'(bus.issue_tag), 2);
        bus.issue_ready = 1;
        bus.cdb_valid = 1;
        bus.cdb_tag = 4'd9;
        bus.cdb_data = 16'hBEEF;
        tick();
        bus.cdb_valid = 0;
        chk("woken_tag", int'(bus.issue_tag), 1);
        chk("woken_r1", int'(bus.issue_r1data), 'hBEEF);
        tick();
        bus.issue_ready = 0;
        chk("woken_drain", int'(bus.count), 0);

        disp(16'h3003, 16'h0030, 4'd4, 1, 0, 16'd3, 0, 4'd5, 16'd0);
        bus.cdb_valid = 1;
        bus.cdb_tag = 4'd5;
        bus.cdb_data = 16'h0042;
        tick();
        bus.disp_valid = 0;
        bus.cdb_valid = 0;
        chk("bypass_valid", int'(bus.issue_valid), 1);
        chk("bypass_r2", int'(bus.issue_r2data), 'h42);
        bus.issue_ready = 1;
        tick();
        bus.issue_ready = 0;

        for (int i = 0; i < 4; i++) begin
            disp(16'h4000 + 16'(i), 16'h0040 + 16'(i), 4'(10 + i), 1, 0, 16'(i), 1, 0, 16'(i + 1));
            tick();
        end
        chk("full_count", int'(bus.count), 4);
        chk("full_ready", int'(bus.disp_ready), 0);
        disp(16'h4004, 16'h0044, 4'd14, 1, 0, 16'd9, 1, 0, 16'd9);
        tick();
        chk("full_held", int'(bus.count), 4);
        bus.issue_ready = 1;
        tick();
        bus.disp_valid = 0;
        bus.issue_ready = 0;
        chk("full_after_count", int'(bus.count), 3);
        chk("full_after_ready", int'(bus.disp_ready), 1);
        chk("full_after_tag", int'(bus.issue_tag), 11);
        bus.issue_ready = 1;
        for (int i = 0; i < 3; i++) tick();
        bus.issue_ready = 0;
        chk("full_drained", int'(bus.count), 0);

        for (int i = 0; i < 3; i++) begin
            disp(16'h5000 + 16'(i), 16'h0050, 4'(i), 1, 0, 16'd1, 1, 0, 16'd2);
            tick();
        end
        bus.flush = 1;
        bus.issue_ready = 1;
        disp(16'h5555, 16'h0055, 4'd7, 1, 0, 16'd1, 1, 0, 16'd1);
        tick();
        chk("flush_count", int'(bus.count), 0);
        chk("flush_valid", int'(bus.issue_valid), 0);
        chk("flush_insn", int'(bus.issue_insn), 0);
        chk("flush_r1", int'(bus.issue_r1data), 0);
        idle();
        tick();

        for (int c = 0; c < 10000; c++) begin
            bus.flush = ($urandom_range(0, 255) == 0);
            bus.disp_valid = $urandom_range(0, 1);
            bus.disp_insn = 16'($urandom);
            bus.disp_pc = 16'($urandom);
            bus.disp_tag = 4'(c);
            bus.disp_r1_rdy = $urandom_range(0, 1);
            bus.disp_r2_rdy = $urandom_range(0, 1);
            bus.disp_r1_tag = 4'($urandom_range(0, 7));
            bus.disp_r2_tag = 4'($urandom_range(0, 7));
            bus.disp_r1_data = 16'($urandom);
            bus.disp_r2_data = 16'($urandom);
            bus.cdb_valid = ($urandom_range(0, 9) < 6);
            bus.cdb_tag = 4'($urandom_range(0, 7));
            bus.cdb_data = 16'($urandom);
            bus.issue_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        idle();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
